// File: rtl/sram_bridge.sv
// sram_bridge: 32-bit word master port to a 16-bit asynchronous SRAM.
// Each word moves as two halfword accesses (low, then high). Each access has
// an access phase of WAIT_CYCLES cycles followed by a one-cycle hold phase.
// All pad-facing signals are registered from the decoded state, so they trail
// the state register by one cycle.
module sram_bridge #(
    parameter int SRAM_ADDRESS_WIDTH = 18,
    parameter int WAIT_CYCLES        = 2
) (
    input  logic                          i_reset,
    input  logic                          i_clock,
    input  logic                          i_rw,
    input  logic                          i_request,
    output logic                          o_ready,
    input  logic [31:0]                   i_address,
    output logic [31:0]                   o_rdata,
    input  logic [31:0]                   i_wdata,
    input  logic [3:0]                    i_wmask,
    output logic [SRAM_ADDRESS_WIDTH-1:0] o_sram_a,
    output logic [15:0]                   o_sram_d,
    input  logic [15:0]                   i_sram_d,
    output logic                          o_sram_d_oe,
    output logic                          o_sram_ce_n,
    output logic                          o_sram_oe_n,
    output logic                          o_sram_we_n,
    output logic                          o_sram_lb_n,
    output logic                          o_sram_ub_n,
    output logic                          o_busy
);

    typedef enum logic [2:0] {
        IDLE, ACC_LO, HOLD_LO, ACC_HI, HOLD_HI, READY, RELEASE
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES - 1);

    state_t                        state, state_next;
    logic                          rw_q;
    logic [SRAM_ADDRESS_WIDTH-2:0] addr_q;
    logic [31:0]                   wdata_q;
    logic [3:0]                    wmask_q;
    logic [3:0]                    cnt;
    logic                          acc_done;
    logic                          lo_en_in, hi_en_in, hi_en_q;
    logic                          hi_sel, acc_sel;

    logic                          ce_d, oe_d, we_d, lb_d, ub_d, doe_d, ready_d;
    logic                          cap_lo_d, cap_hi_d, cap_lo, cap_hi;
    logic [SRAM_ADDRESS_WIDTH-1:0] a_d;
    logic [15:0]                   d_d;

    logic                          unused_addr_bits;
    assign unused_addr_bits = ^i_address[31:SRAM_ADDRESS_WIDTH-1];

    // A read always uses both halves; a write skips halves with no enabled byte.
    assign lo_en_in = !i_rw || (|i_wmask[1:0]);
    assign hi_en_in = !i_rw || (|i_wmask[3:2]);
    assign hi_en_q  = !rw_q || (|wmask_q[3:2]);
    assign acc_done = (cnt == CNT_LAST);
    assign o_busy   = (state != IDLE);

    // State register
    always_ff @(posedge i_clock) begin
        if (i_reset) state <= IDLE;
        else         state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (i_request) begin
                    if (lo_en_in)      state_next = ACC_LO;
                    else if (hi_en_in) state_next = ACC_HI;
                    else               state_next = READY;
                end
            end
            ACC_LO:  if (acc_done) state_next = HOLD_LO;
            HOLD_LO: state_next = hi_en_q ? ACC_HI : READY;
            ACC_HI:  if (acc_done) state_next = HOLD_HI;
            HOLD_HI: state_next = READY;
            READY:   state_next = RELEASE;
            RELEASE: if (!i_request) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request capture on acceptance; later input changes are ignored
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
        end else if (state == IDLE && i_request) begin
            rw_q    <= i_rw;
            addr_q  <= i_address[SRAM_ADDRESS_WIDTH-2:0];
            wdata_q <= i_wdata;
            wmask_q <= i_wmask;
        end
    end

    // Access-phase cycle counter, cleared on every state change
    always_ff @(posedge i_clock) begin
        if (i_reset || state_next != state)           cnt <= '0;
        else if (state == ACC_LO || state == ACC_HI)  cnt <= cnt + 4'd1;
    end

    // Output decode of the current state, feeding the output registers
    always_comb begin
        ce_d     = 1'b1;
        oe_d     = 1'b1;
        we_d     = 1'b1;
        lb_d     = 1'b1;
        ub_d     = 1'b1;
        doe_d    = 1'b0;
        ready_d  = (state == READY);
        cap_lo_d = 1'b0;
        cap_hi_d = 1'b0;
        a_d      = o_sram_a;
        d_d      = o_sram_d;
        hi_sel   = (state == ACC_HI) || (state == HOLD_HI);
        acc_sel  = (state == ACC_LO) || (state == ACC_HI);
        if (state inside {ACC_LO, HOLD_LO, ACC_HI, HOLD_HI}) begin
            ce_d = 1'b0;
            a_d  = {addr_q, hi_sel};
            if (rw_q) begin
                doe_d = 1'b1;
                we_d  = !acc_sel;
                d_d   = hi_sel ? wdata_q[31:16] : wdata_q[15:0];
                lb_d  = !(hi_sel ? wmask_q[2] : wmask_q[0]);
                ub_d  = !(hi_sel ? wmask_q[3] : wmask_q[1]);
            end else begin
                oe_d     = !acc_sel;
                lb_d     = 1'b0;
                ub_d     = 1'b0;
                cap_lo_d = (state == ACC_LO) && acc_done;
                cap_hi_d = (state == ACC_HI) && acc_done;
            end
        end
    end

    // Output registers; read data is sampled at the end of the last visible
    // access cycle, which is one cycle after the state decode flagged it
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_sram_ce_n <= 1'b1;
            o_sram_oe_n <= 1'b1;
            o_sram_we_n <= 1'b1;
            o_sram_lb_n <= 1'b1;
            o_sram_ub_n <= 1'b1;
            o_sram_d_oe <= 1'b0;
            o_ready     <= 1'b0;
            o_sram_a    <= '0;
            o_sram_d    <= '0;
            o_rdata     <= '0;
            cap_lo      <= 1'b0;
            cap_hi      <= 1'b0;
        end else begin
            o_sram_ce_n <= ce_d;
            o_sram_oe_n <= oe_d;
            o_sram_we_n <= we_d;
            o_sram_lb_n <= lb_d;
            o_sram_ub_n <= ub_d;
            o_sram_d_oe <= doe_d;
            o_ready     <= ready_d;
            o_sram_a    <= a_d;
            o_sram_d    <= d_d;
            cap_lo      <= cap_lo_d;
            cap_hi      <= cap_hi_d;
            if (cap_lo) o_rdata[15:0]  <= i_sram_d;
            if (cap_hi) o_rdata[31:16] <= i_sram_d;
        end
    end

endmodule

// File: tb/tb_sram_bridge.sv
// Bench for sram_bridge: directed cases plus random word traffic checked
// against a word-level memory model and a latency/strobe-count model.
module tb_sram_bridge;

    localparam int W = 2;

    logic        clk = 1'b0;
    logic        i_reset, i_rw, i_request;
    logic [31:0] i_address, i_wdata;
    logic [3:0]  i_wmask;
    logic        o_ready, o_busy, o_sram_d_oe;
    logic [31:0] o_rdata;
    logic [17:0] o_sram_a;
    logic [15:0] o_sram_d, i_sram_d;
    logic        o_sram_ce_n, o_sram_oe_n, o_sram_we_n, o_sram_lb_n, o_sram_ub_n;

    int total = 0;
    int bad   = 0;

    sram_bridge #(.SRAM_ADDRESS_WIDTH(18), .WAIT_CYCLES(W)) dut (
        .i_reset(i_reset), .i_clock(clk), .i_rw(i_rw), .i_request(i_request),
        .o_ready(o_ready), .i_address(i_address), .o_rdata(o_rdata),
        .i_wdata(i_wdata), .i_wmask(i_wmask), .o_sram_a(o_sram_a),
        .o_sram_d(o_sram_d), .i_sram_d(i_sram_d), .o_sram_d_oe(o_sram_d_oe),
        .o_sram_ce_n(o_sram_ce_n), .o_sram_oe_n(o_sram_oe_n),
        .o_sram_we_n(o_sram_we_n), .o_sram_lb_n(o_sram_lb_n),
        .o_sram_ub_n(o_sram_ub_n), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    // Content of a never-written SRAM halfword
    function automatic bit [15:0] dflt(input int unsigned ha);
        return 16'((ha * 32'd40503) ^ 32'h5A3C);
    endfunction

    // SRAM model: byte-lane writes while ce_n/we_n low, reads while ce_n/oe_n low
    bit [15:0]  sram_mem [0:1023];
    bit         sram_wr  [0:1023];
    logic [9:0] sidx;
    logic [15:0] sbase;
    assign sidx = o_sram_a[9:0];
    always_comb sbase = sram_wr[sidx] ? sram_mem[sidx] : dflt(32'(sidx));
    assign i_sram_d = (!o_sram_ce_n && !o_sram_oe_n) ? sbase : 16'h0000;
    always @(posedge clk) begin
        if (!o_sram_ce_n && !o_sram_we_n) begin
            sram_mem[sidx] <= {o_sram_ub_n ? sbase[15:8] : o_sram_d[15:8],
                               o_sram_lb_n ? sbase[7:0]  : o_sram_d[7:0]};
            sram_wr[sidx]  <= 1'b1;
        end
    end

    // Reference: word memory, expected read data
    bit [31:0]   ref_word [0:511];
    bit          ref_wr   [0:511];
    logic [31:0] exp_rd = '0;
    logic [15:0] wa_q[$];
    logic [15:0] wd_q[$];

    function automatic bit [31:0] ref_read(input int unsigned a);
        return ref_wr[a] ? ref_word[a] : {dflt(2 * a + 1), dflt(2 * a)};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One transaction from IDLE; caller is just after a negedge
    task automatic run_txn(input bit rw, input bit [31:0] a, input bit [31:0] wd,
                           input bit [3:0] m, input int unsigned extra_hold);
        int lat = 0, we_c = 0, oe_c = 0, ce_c = 0, perr = 0, herr = 0, halves;
        bit got = 0, seen_hi = 0, hi;
        int lane;
        bit [31:0] w;
        halves = rw ? (int'(|m[1:0]) + int'(|m[3:2])) : 2;
        wa_q.delete();
        wd_q.delete();
        i_request = 1'b1; i_rw = rw; i_address = a; i_wdata = wd; i_wmask = m;
        while (!got && lat < 200) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                i_rw = 1'($urandom); i_address = $urandom;
                i_wdata = $urandom; i_wmask = 4'($urandom);
            end
            if (o_ready) got = 1;
            if (!o_sram_ce_n) begin
                ce_c++;
                hi = o_sram_a[0];
                if (hi) seen_hi = 1; else if (seen_hi) perr++;
                if (o_sram_a !== {a[16:0], hi}) perr++;
                lane = hi ? 2 : 0;
                if (rw) begin
                    if (o_sram_oe_n !== 1'b1 || o_sram_d_oe !== 1'b1) perr++;
                    if (o_sram_d !== (hi ? wd[31:16] : wd[15:0])) perr++;
                    if (o_sram_lb_n !== !m[lane] || o_sram_ub_n !== !m[lane + 1]) perr++;
                    if (!o_sram_we_n) begin
                        we_c++;
                        wa_q.push_back(o_sram_a[15:0]);
                        wd_q.push_back(o_sram_d);
                    end
                end else begin
                    if (o_sram_we_n !== 1'b1 || o_sram_d_oe !== 1'b0) perr++;
                    if (o_sram_lb_n !== 1'b0 || o_sram_ub_n !== 1'b0) perr++;
                    if (!o_sram_oe_n) oe_c++;
                end
            end else if ({o_sram_oe_n, o_sram_we_n, o_sram_lb_n, o_sram_ub_n} !== 4'hF
                         || o_sram_d_oe !== 1'b0) begin
                perr++;
            end
        end
        check("ready_seen", 64'(got), 64'd1);
        check("latency", 64'(lat - 1), 64'(1 + halves * (W + 1)));
        check("we_cycles", 64'(we_c), 64'(rw ? halves * W : 0));
        check("oe_cycles", 64'(oe_c), 64'(rw ? 0 : 2 * W));
        check("ce_cycles", 64'(ce_c), 64'(halves * (W + 1)));
        check("protocol", 64'(perr), 64'd0);
        if (rw) begin
            w = ref_read(int'(a[8:0]));
            for (int unsigned b = 0; b < 4; b++)
                if (m[b]) w[8*b +: 8] = wd[8*b +: 8];
            ref_word[a[8:0]] = w;
            ref_wr[a[8:0]]   = 1'b1;
        end else begin
            exp_rd = ref_read(int'(a[8:0]));
        end
        check("rdata_at_ready", 64'(o_rdata), 64'(exp_rd));
        for (int unsigned k = 0; k < extra_hold; k++) begin
            @(negedge clk);
            if (o_ready || !o_sram_ce_n || !o_busy) herr++;
        end
        check("release_hold", 64'(herr), 64'd0);
        i_request = 1'b0;
        i_address = $urandom; i_wdata = $urandom;
        @(negedge clk);
        check("idle_busy", 64'(o_busy), 64'd0);
        check("ready_pulse_end", 64'(o_ready), 64'd0);
        check("rdata_held", 64'(o_rdata), 64'(exp_rd));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned k;
        i_reset = 1'b1; i_request = 1'b0; i_rw = 1'b0;
        i_address = '0; i_wdata = '0; i_wmask = '0;
        repeat (3) @(negedge clk);
        check("rst_strobes", 64'({o_sram_ce_n, o_sram_oe_n, o_sram_we_n, o_sram_lb_n, o_sram_ub_n}), 64'h1F);
        check("rst_ready", 64'(o_ready), 64'd0);
        check("rst_busy", 64'(o_busy), 64'd0);
        check("rst_rdata", 64'(o_rdata), 64'd0);
        check("rst_addr", 64'(o_sram_a), 64'd0);
        check("rst_data", 64'(o_sram_d), 64'd0);
        check("rst_doe", 64'(o_sram_d_oe), 64'd0);

        // Request present in the first cycle after reset release
        i_reset = 1'b0;
        run_txn(1'b1, 32'h5, 32'hB00B_5555, 4'hF, 0);
        check("seq_len", 64'(wa_q.size()), 64'd4);
        check("seq_a0", 64'(wa_q[0]), 64'h0A);
        check("seq_a1", 64'(wa_q[1]), 64'h0A);
        check("seq_a2", 64'(wa_q[2]), 64'h0B);
        check("seq_a3", 64'(wa_q[3]), 64'h0B);
        check("seq_d0", 64'(wd_q[0]), 64'h5555);
        check("seq_d2", 64'(wd_q[2]), 64'hB00B);

        run_txn(1'b1, 32'h5, 32'hDEAD_BEEF, 4'hF, 0);
        run_txn(1'b0, 32'h5, 32'h0, 4'h0, 0);
        check("read_deadbeef", 64'(o_rdata), 64'hDEAD_BEEF);

        // Partial and empty masks, then read back the merged word
        run_txn(1'b1, 32'h10, 32'h1234_5678, 4'b1100, 0);
        run_txn(1'b1, 32'h11, 32'hFFFF_FFFF, 4'b0000, 0);
        run_txn(1'b1, 32'h12, 32'hA1B2_C3D4, 4'b0101, 2);
        run_txn(1'b0, 32'h10, 32'h0, 4'h0, 0);
        run_txn(1'b0, 32'h12, 32'h0, 4'h0, 0);

        // Request held three cycles past o_ready
        run_txn(1'b0, 32'h11, 32'h0, 4'h0, 3);

        // Reset during the high-half access of a write
        i_request = 1'b1; i_rw = 1'b1; i_address = 32'h40;
        i_wdata = 32'h7777_8888; i_wmask = 4'hF;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(o_sram_a[0] && !o_sram_ce_n && !o_sram_we_n) && k < 50);
        check("reach_acc_hi", 64'(k < 50), 64'd1);
        i_reset = 1'b1; i_request = 1'b0;
        @(negedge clk);
        check("abort_strobes", 64'({o_sram_ce_n, o_sram_oe_n, o_sram_we_n, o_sram_lb_n, o_sram_ub_n}), 64'h1F);
        check("abort_doe", 64'(o_sram_d_oe), 64'd0);
        check("abort_ready", 64'(o_ready), 64'd0);
        check("abort_busy", 64'(o_busy), 64'd0);
        exp_rd = '0;
        i_reset = 1'b0;
        run_txn(1'b0, 32'h5, 32'h0, 4'h0, 0);
        check("post_abort_read", 64'(o_rdata), 64'hDEAD_BEEF);

        // Eight back-to-back writes then read one back
        for (int unsigned i = 1; i <= 8; i++)
            run_txn(1'b1, 32'(i), 32'h0101_0101 * i ^ 32'hC0DE_0000, 4'hF, 0);
        run_txn(1'b0, 32'h5, 32'h0, 4'h0, 0);
        check("wbuf_read5", 64'(o_rdata), 64'(32'h0505_0505 ^ 32'hC0DE_0000));

        // Random traffic, away from the aborted word
        for (int unsigned i = 0; i < 40; i++)
            run_txn(1'($urandom), 32'($urandom_range(32'h80, 32'h1FF)), $urandom,
                    ($urandom_range(0, 4) == 0) ? 4'h0 : 4'($urandom),
                    $urandom_range(0, 3));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
